// File: rtl/gshare_bp_param_if.sv
// Fetch/execute-facing signal bundle of the gshare predictor.
// Requests and resolved-branch updates come in, registered predictions go out.
interface gshare_bp_param_if #(
    parameter int PC_W   = 32,
    parameter int HIST_W = 8
) ();
    logic              ready;
    logic              start;
    logic [PC_W-1:0]   branch_address;
    logic [6:0]        opcode;
    logic              pred_valid;
    logic              prediction;
    logic [HIST_W-1:0] pred_ghr;
    logic              update;
    logic [PC_W-1:0]   update_address;
    logic [6:0]        update_opcode;
    logic              branch_taken;
    logic [HIST_W-1:0] update_ghr;
    logic              update_mispredict;

    modport master (
        input  ready, pred_valid, prediction, pred_ghr,
        output start, branch_address, opcode,
        output update, update_address, update_opcode,
        output branch_taken, update_ghr, update_mispredict
    );

    modport slave (
        output ready, pred_valid, prediction, pred_ghr,
        input  start, branch_address, opcode,
        input  update, update_address, update_opcode,
        input  branch_taken, update_ghr, update_mispredict
    );
endinterface

// File: rtl/gshare_bp_param.sv
// Gshare predictor: PHT of 2-bit counters indexed by PC ^ GHR, speculative GHR
// with mispredict recovery, and a power-up walk that initialises every counter.
module gshare_bp_param #(
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 8,
    parameter int         HIST_W   = 8,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    gshare_bp_param_if.slave  bp
);
    localparam int         DEPTH      = 2 ** IDX_W;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    init_ptr_q, init_ptr_d;
    logic [HIST_W-1:0]   ghr_q, ghr_d;
    logic                ready_q, ready_d;
    logic                pred_valid_q, pred_valid_d;
    logic                prediction_q, prediction_d;
    logic [HIST_W-1:0]   pred_ghr_q, pred_ghr_d;

    logic [1:0]          pht_q [DEPTH];
    logic                pht_we_s;
    logic [IDX_W-1:0]    pht_waddr_s;
    logic [1:0]          pht_wdata_s;
    logic [IDX_W-1:0]    pred_idx_s;
    logic [IDX_W-1:0]    upd_idx_s;
    logic                pred_bit_s;

    function automatic logic [IDX_W-1:0] zext_hist(input logic [HIST_W-1:0] h);
        logic [IDX_W-1:0] r;
        r              = '0;
        r[HIST_W-1:0]  = h;
        return r;
    endfunction

    function automatic logic [1:0] sat_count(input logic [1:0] cnt, input logic taken);
        logic [1:0] r;
        case ({taken, cnt})
            3'b1_11: r = 2'b11;
            3'b0_00: r = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: r = cnt + 2'b01;
            3'b0_01, 3'b0_10, 3'b0_11: r = cnt - 2'b01;
            default: r = cnt;
        endcase
        return r;
    endfunction

    assign pred_idx_s = bp.branch_address[IDX_W+1:2] ^ zext_hist(ghr_q);
    assign upd_idx_s  = bp.update_address[IDX_W+1:2] ^ zext_hist(bp.update_ghr);

    // Next-state, PHT write port and speculative/recovered GHR selection
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        ghr_d        = ghr_q;
        ready_d      = ready_q;
        pred_valid_d = 1'b0;
        prediction_d = prediction_q;
        pred_ghr_d   = pred_ghr_q;
        pht_we_s     = 1'b0;
        pht_waddr_s  = '0;
        pht_wdata_s  = CNT_INIT;
        pred_bit_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                pht_we_s    = 1'b1;
                pht_waddr_s = init_ptr_q;
                pht_wdata_s = CNT_INIT;
                init_ptr_d  = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (bp.start) begin
                    pred_valid_d = 1'b1;
                    pred_ghr_d   = ghr_q;
                    case (bp.opcode)
                        OPC_BRANCH: begin
                            pred_bit_s = pht_q[pred_idx_s][1];
                            ghr_d      = {ghr_q[HIST_W-2:0], pred_bit_s};
                        end
                        OPC_JAL, OPC_JALR: pred_bit_s = 1'b1;
                        default:           pred_bit_s = 1'b0;
                    endcase
                    prediction_d = pred_bit_s;
                end else begin
                    pred_valid_d = 1'b0;
                end
                // Recovery wins over the speculative shift of a same-cycle start
                if (bp.update && (bp.update_opcode == OPC_BRANCH)) begin
                    pht_we_s    = 1'b1;
                    pht_waddr_s = upd_idx_s;
                    pht_wdata_s = sat_count(pht_q[upd_idx_s], bp.branch_taken);
                    if (bp.update_mispredict) begin
                        ghr_d = {bp.update_ghr[HIST_W-2:0], bp.branch_taken};
                    end else begin
                        ghr_d = ghr_d;
                    end
                end else begin
                    pht_we_s = 1'b0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
                ready_d    = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            ghr_q        <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ghr_q        <= ghr_d;
            ready_q      <= ready_d;
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    // Counter table; contents are rebuilt by the init walk after every reset
    always_ff @(posedge clk) begin
        if (pht_we_s && !rst) begin
            pht_q[pht_waddr_s] <= pht_wdata_s;
        end
    end

    assign bp.ready      = ready_q;
    assign bp.pred_valid = pred_valid_q;
    assign bp.prediction = prediction_q;
    assign bp.pred_ghr   = pred_ghr_q;
endmodule
